// File: rtl/ro_meas_sequencer.sv
// rtl/ro_meas_sequencer.sv - ring-oscillator measurement sequencer
// Time-shares one ripple event counter across N_CH oscillators, one window per masked channel.
module ro_meas_sequencer #(
  parameter int N_CH   = 4,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [N_CH-1:0]   i_ChMask,
  input  logic [WIN_W-1:0]  i_Window,
  input  logic [15:0]       i_Cnt,
  input  logic              i_Ready,
  output logic [N_CH-1:0]   o_RoEn,
  output logic              o_CntEn,
  output logic              o_CntRstN,
  output logic              o_Busy,
  output logic              o_Valid,
  output logic [15:0]       o_Data,
  output logic [CH_W-1:0]   o_DataCh,
  output logic              o_Done
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE_ST, CAPT, HOLD, DONE} state_t;

  localparam logic [WIN_W-1:0] SETTLE_M1 = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] ONE       = WIN_W'(1);

  state_t            state;
  logic [N_CH-1:0]   mask_q;
  logic [WIN_W-1:0]  win_q;
  logic [WIN_W-1:0]  timer;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              next_found;
  logic [WIN_W-1:0]  win_eff;

  assign win_eff = (i_Window == '0) ? ONE : i_Window;

  // Downward scan so the last hit is the lowest qualifying index.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ChMask[i]) first_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(ch))) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      win_q     <= '0;
      timer     <= '0;
      ch        <= '0;
      o_RoEn    <= '0;
      o_CntEn   <= 1'b0;
      o_CntRstN <= 1'b0;
      o_Busy    <= 1'b0;
      o_Valid   <= 1'b0;
      o_Data    <= '0;
      o_DataCh  <= '0;
      o_Done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_RoEn    <= '0;
          o_CntEn   <= 1'b0;
          o_CntRstN <= 1'b0;
          o_Done    <= 1'b0;
          if (i_Start) begin
            mask_q <= i_ChMask;
            win_q  <= win_eff;
            o_Busy <= 1'b1;
            if (|i_ChMask) begin
              ch     <= first_ch;
              o_RoEn <= N_CH'(1) << first_ch;
              timer  <= ONE;
              state  <= CLR;
            end else begin
              state <= DONE;
            end
          end
        end
        CLR: begin
          if (timer == '0) begin
            o_CntRstN <= 1'b1;
            o_CntEn   <= 1'b1;
            timer     <= win_q - ONE;
            state     <= RUN;
          end else begin
            timer <= timer - ONE;
          end
        end
        RUN: begin
          if (timer == '0) begin
            o_CntEn <= 1'b0;
            o_RoEn  <= '0;
            timer   <= SETTLE_M1;
            state   <= SETTLE_ST;
          end else begin
            timer <= timer - ONE;
          end
        end
        SETTLE_ST: begin
          if (timer == '0) state <= CAPT;
          else             timer <= timer - ONE;
        end
        CAPT: begin
          // The counter reads one less than the true edge count.
          o_Data   <= i_Cnt + 16'd1;
          o_DataCh <= ch;
          o_Valid  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (i_Ready) begin
            o_Valid   <= 1'b0;
            o_CntRstN <= 1'b0;
            if (next_found) begin
              ch     <= next_ch;
              o_RoEn <= N_CH'(1) << next_ch;
              timer  <= ONE;
              state  <= CLR;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // First cycle raises o_Done, second drops it together with o_Busy.
          if (!o_Done) begin
            o_Done <= 1'b1;
          end else begin
            o_Done <= 1'b0;
            o_Busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// tb/tb_ro_meas_sequencer.sv - directed self-checking bench for ro_meas_sequencer
module tb_ro_meas_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ch_mask;
  logic [15:0] window;
  logic [15:0] cnt;
  logic        ready;
  logic [3:0]  ro_en;
  logic        cnt_en;
  logic        cnt_rstn;
  logic        busy;
  logic        valid;
  logic [15:0] data;
  logic [1:0]  data_ch;
  logic        done;

  ro_meas_sequencer #(.N_CH(4), .WIN_W(16), .SETTLE(4)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_ChMask(ch_mask), .i_Window(window),
    .i_Cnt(cnt), .i_Ready(ready), .o_RoEn(ro_en), .o_CntEn(cnt_en), .o_CntRstN(cnt_rstn),
    .o_Busy(busy), .o_Valid(valid), .o_Data(data), .o_DataCh(data_ch), .o_Done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rate = 1;
  logic multi_hot = 1'b0;
  logic pv = 1'b0;
  logic pd = 1'b0;
  int done_cnt = 0;
  int done_edge = 0;
  int res_data[$];
  int res_ch[$];
  int res_edge[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Inverted-state counter model: 0xFFFF after clear, advances 'rate' edges per gated cycle.
  always @(posedge clk) begin
    if (!cnt_rstn)   cnt <= 16'hFFFF;
    else if (cnt_en) cnt <= cnt + 16'(rate);
  end

  always @(negedge clk) begin
    if ($countones(ro_en) > 1) multi_hot = 1'b1;
    if (valid && !pv) begin
      res_data.push_back(int'(data));
      res_ch.push_back(int'(data_ch));
      res_edge.push_back(cyc);
    end
    if (done && !pd) begin
      done_cnt++;
      done_edge = cyc;
    end
    pv = valid;
    pd = done;
  end

  task automatic start_sweep(input logic [3:0] m, input logic [15:0] w, output int k);
    @(negedge clk);
    ch_mask = m; window = w; start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int t = 0;
    while (done_cnt == n0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == n0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n, input int budget);
    int t = 0;
    while (res_data.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (res_data.size() < n) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int k;
    int n0;
    int t;
    rst = 1'b0; start = 1'b0; ch_mask = '0; window = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_roen", 32'(ro_en), 0);
    check("rst_cntrstn", 32'(cnt_rstn), 0);
    check("rst_busy_valid_done", {busy, valid, done}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel, W=10: valid at k+17, data 10, done two edges after valid rises.
    res_data.delete(); res_ch.delete(); res_edge.delete();
    n0 = done_cnt;
    start_sweep(4'b0001, 16'd10, k);
    check("t1_busy", 32'(busy), 1);
    wait_done(n0, 200);
    check("t1_count", res_data.size(), 1);
    if (res_data.size() >= 1) begin
      check("t1_edge", res_edge[0], k + 17);
      check("t1_data", res_data[0], 10);
      check("t1_ch", res_ch[0], 0);
      check("t1_done_edge", done_edge, k + 19);
    end
    @(negedge clk);
    check("t1_idle", {busy, done, cnt_rstn}, 0);

    // Mask 1010 with backpressure and a dropped start mid-sweep.
    res_data.delete(); res_ch.delete(); res_edge.delete();
    ready = 1'b0;
    n0 = done_cnt;
    start_sweep(4'b1010, 16'd100, k);
    wait_results(1, 400);
    @(negedge clk);
    ch_mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    check("t2_hold_valid", 32'(valid), 1);
    check("t2_hold_data", 32'(data), 100);
    check("t2_hold_ch", 32'(data_ch), 1);
    ready = 1'b1;
    @(negedge clk);
    check("t2_valid_drop", 32'(valid), 0);
    check("t2_next_clr", {28'd0, ro_en, cnt_rstn}, {28'd0, 4'b1000, 1'b0});
    wait_done(n0, 400);
    check("t2_count", res_data.size(), 2);
    if (res_data.size() >= 2) begin
      check("t2_data3", res_data[1], 100);
      check("t2_ch3", res_ch[1], 3);
    end
    repeat (4) @(negedge clk);
    check("t2_no_extra_sweep", {busy, 3'd0, res_data.size() == 2}, {1'b0, 3'd0, 1'b1});

    // Zero mask: done at k+1, no results.
    res_data.delete(); res_ch.delete(); res_edge.delete();
    n0 = done_cnt;
    start_sweep(4'b0000, 16'd7, k);
    wait_done(n0, 20);
    check("t3_done_edge", done_edge, k + 1);
    @(negedge clk);
    check("t3_busy_low", 32'(busy), 0);
    check("t3_no_valid", res_data.size(), 0);

    // Dead oscillator: 0xFFFF + 1 wraps to 0; then 65537 edges give 1.
    rate = 0;
    n0 = done_cnt;
    start_sweep(4'b0001, 16'd1, k);
    wait_done(n0, 100);
    check("t4_dead", res_data.size() >= 1 ? res_data[0] : -1, 0);
    res_data.delete(); res_ch.delete(); res_edge.delete();
    rate = 65537;
    n0 = done_cnt;
    start_sweep(4'b0001, 16'd1, k);
    wait_done(n0, 100);
    check("t4_wrap", res_data.size() >= 1 ? res_data[0] : -1, 1);
    rate = 1;

    // Asynchronous reset during RUN of ch2.
    res_data.delete(); res_ch.delete(); res_edge.delete();
    start_sweep(4'b0101, 16'd50, k);
    t = 0;
    while (!(ro_en == 4'b0100 && cnt_en) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t5_reach_ch2", {ro_en, cnt_en}, {4'b0100, 1'b1});
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_outs", {ro_en, cnt_en, cnt_rstn, busy, valid, done, data_ch}, 0);
    check("t5_rst_data", 32'(data), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    res_data.delete(); res_ch.delete(); res_edge.delete();
    n0 = done_cnt;
    start_sweep(4'b0001, 16'd5, k);
    wait_done(n0, 100);
    check("t5_after_data", res_data.size() >= 1 ? res_data[0] : -1, 5);
    check("t5_after_ch", res_ch.size() >= 1 ? res_ch[0] : -1, 0);

    // Window 0 behaves as one RUN cycle.
    res_data.delete(); res_ch.delete(); res_edge.delete();
    n0 = done_cnt;
    start_sweep(4'b0001, 16'd0, k);
    wait_done(n0, 100);
    check("t6_data", res_data.size() >= 1 ? res_data[0] : -1, 1);
    check("t6_edge", res_edge.size() >= 1 ? res_edge[0] : -1, k + 8);

    check("onehot_roen", 32'(multi_hot), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
